// File: rtl/adc_conv_rd_if.sv
// Pin and result bundle of the periodic ADC conversion/readback controller.
// o_adc_valid is a one-cycle pulse with no back-pressure: o_adc_data is new in that cycle and held afterwards.
interface adc_conv_rd_if;
    logic        o_adc_cnv;
    logic        i_adc_busy;
    logic        o_adc_cs_n;
    logic        o_adc_sck;
    logic        i_adc_sdo;
    logic [23:0] o_adc_data;
    logic        o_adc_valid;
    logic        o_timeout;
    logic        o_overrun;

    modport master (
        output o_adc_cnv, o_adc_cs_n, o_adc_sck,
        output o_adc_data, o_adc_valid, o_timeout, o_overrun,
        input  i_adc_busy, i_adc_sdo
    );

    modport slave (
        input  o_adc_cnv, o_adc_cs_n, o_adc_sck,
        input  o_adc_data, o_adc_valid, o_timeout, o_overrun,
        output i_adc_busy, i_adc_sdo
    );
endinterface

// File: rtl/adc_conv_rd.sv
// Periodic CNV pulse, BUSY wait with timeout, 24-bit SPI readback of the ADC sample.
// Build macro ADC_TEST_PATTERN_EN replaces the read word with a counting test pattern.
module adc_conv_rd #(
    parameter int CONV_PERIOD  = 400,
    parameter int CNV_HIGH     = 4,
    parameter int SCK_HALF     = 2,
    parameter int BUSY_TIMEOUT = 200
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    adc_conv_rd_if.master        adc,
    output logic [2:0]           state_dbg
);
    localparam int PW   = (CONV_PERIOD > 1) ? $clog2(CONV_PERIOD) : 1;
    localparam int T1   = (CNV_HIGH > 2 * SCK_HALF) ? CNV_HIGH : 2 * SCK_HALF;
    localparam int TMAX = (T1 > BUSY_TIMEOUT) ? T1 : BUSY_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PERIOD_LAST = PW'(CONV_PERIOD - 1);
    localparam logic [TW-1:0] CNV_LAST    = TW'(CNV_HIGH - 1);
    localparam logic [TW-1:0] BUSY_LIMIT  = TW'(BUSY_TIMEOUT);
    localparam logic [TW-1:0] SCK_RISE    = TW'(SCK_HALF);
    localparam logic [TW-1:0] SCK_LAST    = TW'(2 * SCK_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_BUSY_WAIT, S_READ, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] timer, timer_nxt;
    logic [4:0]    bit_cnt, bit_cnt_nxt;
    logic [23:0]   shift_reg;
    logic [23:0]   load_word;
    logic [23:0]   data;
    logic          busy_meta, busy_sync;
    logic          tick, sample, load, timeout_set;
    logic          valid, timeout, overrun;

    assign tick = i_en && (period_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            period_cnt <= '0;
        end else if (!i_en) begin
            period_cnt <= '0;
        end else if (period_cnt == PERIOD_LAST) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // One timer is shared: CNV width in CONV, BUSY wait length, then SCK phase in READ.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_cnt_nxt = bit_cnt;
        sample      = 1'b0;
        load        = 1'b0;
        timeout_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    state_nxt = S_CONV;
                    timer_nxt = '0;
                end
            end
            S_CONV: begin
                if (timer == CNV_LAST) begin
                    state_nxt = S_BUSY_WAIT;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_BUSY_WAIT: begin
                if (!busy_sync) begin
                    state_nxt   = S_READ;
                    timer_nxt   = '0;
                    bit_cnt_nxt = '0;
                end else if (timer == BUSY_LIMIT) begin
                    state_nxt   = S_IDLE;
                    timeout_set = 1'b1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_READ: begin
                if (timer == SCK_LAST) begin
                    sample    = 1'b1;
                    timer_nxt = '0;
                    if (bit_cnt == 5'd23) begin
                        state_nxt = S_DONE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_DONE: begin
                load      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // BUSY comes from the ADC clock-free logic, so it is resynchronised before use.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            busy_meta <= 1'b0;
            busy_sync <= 1'b0;
            shift_reg <= '0;
            data      <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            busy_meta <= adc.i_adc_busy;
            busy_sync <= busy_meta;
            if (sample) begin
                shift_reg <= {shift_reg[22:0], adc.i_adc_sdo};
            end
            if (load) begin
                data <= load_word;
            end
            valid   <= load;
            timeout <= timeout_set;
            overrun <= tick && (state != S_IDLE);
        end
    end

`ifdef ADC_TEST_PATTERN_EN
    logic [23:0] pattern_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pattern_cnt <= '0;
        end else if (load) begin
            pattern_cnt <= pattern_cnt + 24'd1;
        end
    end

    assign load_word = pattern_cnt + 24'd1;
`else
    assign load_word = shift_reg;
`endif

    assign adc.o_adc_cnv   = (state == S_CONV);
    assign adc.o_adc_cs_n  = (state != S_READ);
    assign adc.o_adc_sck   = (state == S_READ) && (timer >= SCK_RISE);
    assign adc.o_adc_data  = data;
    assign adc.o_adc_valid = valid;
    assign adc.o_timeout   = timeout;
    assign adc.o_overrun   = overrun;
    assign state_dbg       = state;
endmodule

// File: tb/tb_adc_conv_rd.sv
// Self-checking bench for adc_conv_rd: behavioural ADC model, vector table, random phases.
// A second instance with CONV_PERIOD=50 exercises tick overrun.
module tb_adc_conv_rd;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       en_f;
    logic [2:0] state_dbg, state_dbg_f;

    adc_conv_rd_if adc_if();
    adc_conv_rd_if adc_f();

    adc_conv_rd u_dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .adc(adc_if), .state_dbg(state_dbg)
    );

    adc_conv_rd #(.CONV_PERIOD(50)) u_dut_fast (
        .i_clk(clk), .i_rst(rst), .i_en(en_f), .adc(adc_f), .state_dbg(state_dbg_f)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    int          total = 0;
    int          bad = 0;
    logic [23:0] exp_q[$];
    int          valid_cyc[$];
    int          pat_model = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // ADC model: BUSY after CNV, SDO shifted out MSB first, next bit after each SCK fall
    logic [23:0] cur_word = 24'h0;
    int          cur_busy = 10;
    bit          stuck_busy = 0;
    bit          rand_mode = 0;
    bit          rand_busy = 0;
    int          busy_left = 0;
    int          fall_cnt = 0;
    int          rises = 0;
    int          last_read_rises = 0;
    int          last_fall_cyc = 0;
    int          cnv_fall_cyc = 0;
    int          to_delay = 0;
    int          n_valid = 0, n_timeout = 0, n_overrun = 0;
    bit          overlap_seen = 0, double_valid = 0;
    logic        cnv_d = 0, sck_d = 0, cs_n_d = 1, valid_d = 0;
    logic [23:0] popped, exp_word;

    always @(negedge clk) begin
        if (!rst) begin
            adc_if.i_adc_busy = 1'b0;
            adc_if.i_adc_sdo  = 1'b0;
            busy_left = 0;
            fall_cnt  = 0;
            rises     = 0;
            cnv_d = 0; sck_d = 0; cs_n_d = 1; valid_d = 0;
        end else begin
            if (adc_if.o_adc_cnv && !cnv_d) begin
                if (rand_mode) cur_word = 24'($urandom());
                if (rand_busy) cur_busy = $urandom_range(3, 150);
                adc_if.i_adc_busy = 1'b1;
                busy_left = cur_busy;
                if (!stuck_busy) exp_q.push_back(cur_word);
            end else if (adc_if.i_adc_busy && !stuck_busy) begin
                if (busy_left > 0) busy_left--;
                if (busy_left == 0) adc_if.i_adc_busy = 1'b0;
            end
            if (!adc_if.o_adc_cnv && cnv_d) cnv_fall_cyc = cyc;
            if (cs_n_d && !adc_if.o_adc_cs_n) rises = 0;
            if (adc_if.o_adc_sck && !sck_d) rises++;
            if (!adc_if.o_adc_sck && sck_d) begin
                fall_cnt++;
                last_fall_cyc = cyc;
            end
            if (adc_if.o_adc_cs_n) begin
                if (!cs_n_d) last_read_rises = rises;
                fall_cnt = 0;
            end
            adc_if.i_adc_sdo = (fall_cnt < 24) ? cur_word[23 - fall_cnt] : 1'b0;

            if (adc_if.o_adc_valid) begin
                n_valid++;
                valid_cyc.push_back(cyc);
                check("valid_latency_after_last_sck_fall", cyc - last_fall_cyc, 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: actual data=0x%0h required no valid", adc_if.o_adc_data);
                end else begin
                    popped = exp_q.pop_front();
`ifdef ADC_TEST_PATTERN_EN
                    pat_model++;
                    exp_word = 24'(pat_model);
`else
                    exp_word = popped;
`endif
                    check("sample_data", adc_if.o_adc_data, exp_word);
                end
            end
            if (adc_if.o_adc_valid && valid_d) double_valid = 1;
            if (adc_if.o_timeout) begin
                n_timeout++;
                to_delay = cyc - cnv_fall_cyc;
            end
            if (adc_if.o_overrun) n_overrun++;
            if (adc_if.o_adc_cnv && adc_if.o_adc_sck) overlap_seen = 1;
            cnv_d   = adc_if.o_adc_cnv;
            sck_d   = adc_if.o_adc_sck;
            cs_n_d  = adc_if.o_adc_cs_n;
            valid_d = adc_if.o_adc_valid;
        end
    end

    // simple ADC for the fast instance: BUSY 10 clocks, SDO always 1
    int   busy_left_f = 0;
    int   n_valid_f = 0, n_over_f = 0;
    bit   overlap_f = 0;
    logic cnv_fd = 0;

    always @(negedge clk) begin
        adc_f.i_adc_sdo = 1'b1;
        if (!rst) begin
            adc_f.i_adc_busy = 1'b0;
            busy_left_f = 0;
            cnv_fd = 0;
        end else begin
            if (adc_f.o_adc_cnv && !cnv_fd) begin
                adc_f.i_adc_busy = 1'b1;
                busy_left_f = 10;
            end else if (adc_f.i_adc_busy) begin
                if (busy_left_f > 0) busy_left_f--;
                if (busy_left_f == 0) adc_f.i_adc_busy = 1'b0;
            end
            if (adc_f.o_adc_valid) n_valid_f++;
            if (adc_f.o_overrun) n_over_f++;
            if (adc_f.o_adc_cnv && adc_f.o_adc_sck) overlap_f = 1;
            cnv_fd = adc_f.o_adc_cnv;
        end
    end

    typedef struct {
        logic [23:0] word;
        int          busy;
        bit          stuck;
        logic [23:0] exp_data;
        bit          exp_valid;
    } vec_t;

    vec_t        vecs[7];
    logic [2:0]  idle_code;
    int          v0, t0, o0, g;
    logic [23:0] exp_fast;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=time limit reached required=run completes");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{24'h800000, 20,  1'b0, 24'h800000, 1'b1};
        vecs[1] = '{24'h7FFFFF, 50,  1'b0, 24'h7FFFFF, 1'b1};
        vecs[2] = '{24'h000000, 5,   1'b0, 24'h000000, 1'b1};
        vecs[3] = '{24'hFFFFFF, 120, 1'b0, 24'hFFFFFF, 1'b1};
        vecs[4] = '{24'hA5A5A5, 1,   1'b0, 24'hA5A5A5, 1'b1};
        vecs[5] = '{24'h5A5A5A, 1,   1'b1, 24'hA5A5A5, 1'b0};
        vecs[6] = '{24'h123456, 190, 1'b0, 24'h123456, 1'b1};
`ifdef ADC_TEST_PATTERN_EN
        begin
            int p;
            p = 0;
            for (int i = 0; i < 7; i++) begin
                if (vecs[i].exp_valid) p++;
                vecs[i].exp_data = 24'(p);
            end
        end
        exp_fast = 24'd10;
`else
        exp_fast = 24'hFFFFFF;
`endif

        // reset state
        rst = 1'b0; en = 1'b0; en_f = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_outputs",
              {8'h0, adc_if.o_adc_cnv, adc_if.o_adc_cs_n, adc_if.o_adc_sck, adc_if.o_adc_valid,
               adc_if.o_timeout, adc_if.o_overrun, 2'b0, adc_if.o_adc_data},
              {8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b0, 24'h0});
        idle_code = state_dbg;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // vector table: one conversion per row
        for (int i = 0; i < 7; i++) begin
            cur_word   = vecs[i].word;
            cur_busy   = vecs[i].busy;
            stuck_busy = vecs[i].stuck;
            v0 = n_valid;
            t0 = n_timeout;
            en = 1'b1;
            g = 0;
            while (!adc_if.o_adc_cnv && g < 20) begin @(negedge clk); g++; end
            en = 1'b0;
            g = 0;
            while (n_valid == v0 && n_timeout == t0 && g < 600) begin @(negedge clk); g++; end
            repeat (3) @(negedge clk);
            check($sformatf("row%0d_valid_count", i), n_valid - v0, {31'b0, vecs[i].exp_valid});
            check($sformatf("row%0d_timeout_count", i), n_timeout - t0, {31'b0, !vecs[i].exp_valid});
            check($sformatf("row%0d_data", i), adc_if.o_adc_data, vecs[i].exp_data);
            if (i == 0) check("row0_sck_rising_edges", last_read_rises, 24);
            if (vecs[i].stuck) begin
                check_range("timeout_delay_after_cnv_fall", to_delay, 200, 204);
                stuck_busy = 0;
            end
            g = 0;
            while (state_dbg != idle_code && g < 600) begin @(negedge clk); g++; end
            repeat (5) @(negedge clk);
        end

        // periodic: fixed BUSY, random words
        rand_mode = 1; rand_busy = 0; cur_busy = 40;
        valid_cyc.delete();
        o0 = n_overrun;
        en = 1'b1;
        repeat (1990) @(negedge clk);
        en = 1'b0;
        repeat (400) @(negedge clk);
        check("periodic_valid_count", valid_cyc.size(), 5);
        for (int i = 1; i < valid_cyc.size(); i++)
            check($sformatf("periodic_spacing_%0d", i), valid_cyc[i] - valid_cyc[i-1], 400);
        check("periodic_overrun_count", n_overrun - o0, 0);

        // random enable toggling with random BUSY lengths
        rand_busy = 1;
        for (int i = 0; i < 15; i++) begin
            en = 1'($urandom_range(0, 1));
            repeat ($urandom_range(30, 700)) @(negedge clk);
        end
        en = 1'b0;
        repeat (600) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        // reset in the middle of READ
        rand_mode = 0; rand_busy = 0;
        cur_word = 24'h123456; cur_busy = 10;
        en = 1'b1;
        g = 0;
        while (!(adc_if.o_adc_cs_n == 1'b0 && fall_cnt == 12) && g < 800) begin @(negedge clk); g++; end
        check("reached_read_bit12", {31'b0, g < 800}, 1);
        rst = 1'b0;
        #1;
        check("abort_cs_n", adc_if.o_adc_cs_n, 1);
        check("abort_sck", adc_if.o_adc_sck, 0);
        check("abort_data", adc_if.o_adc_data, 0);
        exp_q.delete();
        pat_model = 0;
        cur_word = 24'h7FFFFF;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        v0 = n_valid;
        @(negedge clk);
        check("conv_on_first_clock_after_reset", adc_if.o_adc_cnv, 1);
        en = 1'b0;
        g = 0;
        while (n_valid == v0 && g < 600) begin @(negedge clk); g++; end
        repeat (2) @(negedge clk);
        check("post_reset_valid_count", n_valid - v0, 1);
`ifdef ADC_TEST_PATTERN_EN
        check("post_reset_data", adc_if.o_adc_data, 24'h000001);
`else
        check("post_reset_data", adc_if.o_adc_data, 24'h7FFFFF);
`endif

        // overrun with CONV_PERIOD=50: one conversion per three ticks
        en_f = 1'b1;
        repeat (1480) @(negedge clk);
        en_f = 1'b0;
        g = 0;
        while (state_dbg_f != idle_code && g < 300) begin @(negedge clk); g++; end
        repeat (20) @(negedge clk);
        check("fast_valid_count", n_valid_f, 10);
        check("fast_overrun_count", n_over_f, 20);
        check("fast_data", adc_f.o_adc_data, exp_fast);
        check("fast_no_cnv_sck_overlap", {31'b0, overlap_f}, 0);

        check("no_cnv_sck_overlap", {31'b0, overlap_seen}, 0);
        check("valid_single_cycle", {31'b0, double_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
